fuyang_beam_scheduler: RTL and testbench
========================================

// Module: fuyang_beam_scheduler
// PURPOSE
//  Sequences the elevation (fuyang) beam index that selects per-beam CORDIC phase weights.
//  Steps beam_idx from beam_first to beam_last and requests each beam's coefficients.
//  Waits for the coefficient datapath to confirm, then holds each beam for dwell_len cycles.
//  Sits between radar timing control and the elevation coefficient selector; beam_idx drives its index input c.
// PARAMETERS
//  N_BEAMS   70    highest legal beam index (legal range 1..N_BEAMS; 0 = no beam, zero weights)
//  IDX_W     7     beam index width
//  DWELL_W   16    dwell counter width
//  TMO       255   max cycles to wait for coef_valid before fault
// PORTS
//  clk          in   1        system clock; single clock domain
//  rst          in   1        synchronous, active-high reset
//  start        in   1        1-cycle pulse: begin a scan (accepted in IDLE only)
//  stop         in   1        abort scan immediately (level or pulse)
//  continuous   in   1        1: wrap to beam_first after beam_last; 0: single frame
//  beam_first   in   IDX_W    first beam of scan, latched on accepted start
//  beam_last    in   IDX_W    last beam of scan, latched on accepted start
//  dwell_len    in   DWELL_W  dwell cycles per beam, latched on accepted start
//  coef_valid   in   1        selector output for current beam_idx is valid
//  beam_idx     out  IDX_W    current beam index to the coefficient selector
//  coef_req     out  1        1-cycle pulse: new beam_idx presented
//  beam_active  out  1        high during dwell; coefficients are stable
//  beam_done    out  1        1-cycle pulse at end of each beam dwell
//  frame_done   out  1        1-cycle pulse with beam_done of beam_last
//  busy         out  1        high in any state except IDLE
//  fault        out  1        1-cycle pulse: bad config on start, or coef_valid timeout
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, including beam_idx; latched config cleared.
//  States: IDLE -> SELECT -> WAIT_COEF -> DWELL -> NEXT -> (SELECT | IDLE).
//  IDLE: start with legal config -> SELECT next cycle with beam_idx=beam_first.
//    Legal config: 1<=beam_first<=beam_last<=N_BEAMS.
//    Illegal config: fault pulses the next cycle; state stays IDLE.
//  SELECT: exactly 1 cycle with coef_req=1; beam_idx already updated.
//  WAIT_COEF: coef_valid is sampled here only, not in SELECT.
//    coef_valid=1 -> DWELL.
//    TMO cycles elapse without coef_valid -> fault pulse; IDLE; beam_idx=0.
//  DWELL: beam_active=1 for exactly max(dwell_len,1) cycles; dwell_len=0 is treated as 1.
//  NEXT: 1 cycle; beam_done=1.
//    beam_idx<beam_last: beam_idx+1 and go to SELECT.
//    beam_idx==beam_last: frame_done=1.
//      continuous=1: beam_idx=beam_first and go to SELECT.
//      continuous=0: go to IDLE with beam_idx=0.
//  Per-beam period = 1 (SELECT) + k (WAIT_COEF, k>=1) + dwell + 1 (NEXT).
//  stop in any non-IDLE state: IDLE next cycle; beam_idx=0; all pulses suppressed that cycle.
//  stop and start in the same cycle in IDLE: stop wins; start is ignored.
//  start while busy: ignored. Config inputs may change mid-scan without effect; they are latched.
//  beam_idx only changes on entry to SELECT or on return to IDLE; it never exceeds N_BEAMS.
//  rst mid-scan: same as reset; no done or fault pulse is emitted.
// STRUCTURE
//  Shared package fuyang_pkg: N_BEAMS, IDX_W, state enum (IDLE..NEXT), beam_idx_t typedef.
//  Sub-module fuyang_dwell_timer: loadable down-counter (load, cnt, expire) used for DWELL.
//  The TMO counter is local to the FSM.
// TESTING
//  1. first=3, last=5, dwell=4, continuous=0, coef_valid 1 cycle after coef_req
//     -> beam_idx 3,4,5; beam_active 4 cycles each; 3 beam_done; frame_done on 3rd;
//        busy low 1 cycle after; each beam period = 7 cycles.
//  2. first=70, last=70, continuous=1, dwell=0 -> beam_idx stays 70;
//     frame_done every 4 cycles (1-cycle dwell); stop -> IDLE, beam_idx=0 next cycle.
//  3. first=6, last=2 (also first=0, and last=71) -> fault pulse; busy stays 0; no coef_req.
//  4. coef_valid held 0 after coef_req -> fault exactly TMO cycles into WAIT_COEF;
//     IDLE; beam_idx=0.
//  5. start and stop in the same cycle -> no busy; start during scan -> ignored;
//     change dwell_len mid-scan -> no effect on the running scan.
//  6. rst asserted in DWELL of beam 4 -> all outputs 0 next cycle; no beam_done or frame_done.

Source files
------------

// File: rtl/fuyang_pkg.sv
// Shared definitions for the elevation (fuyang) beam scheduler: sizes,
// scheduler state encoding, beam index type and the scan config check.
package fuyang_pkg;

  localparam int N_BEAMS = 70;   // highest legal beam index; 0 means no beam
  localparam int IDX_W   = 7;
  localparam int DWELL_W = 16;
  localparam int TMO     = 255;  // cycles allowed in WAIT_COEF before fault
  localparam int TMO_W   = 8;

  typedef logic [IDX_W-1:0]   beam_idx_t;
  typedef logic [DWELL_W-1:0] dwell_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SELECT    = 3'd1,
    ST_WAIT_COEF = 3'd2,
    ST_DWELL     = 3'd3,
    ST_NEXT      = 3'd4
  } state_t;

  // A scan is legal when 1 <= first <= last <= N_BEAMS.
  function automatic logic cfg_legal(input beam_idx_t first, input beam_idx_t last);
    return (first != '0) && (first <= last) && (last <= beam_idx_t'(N_BEAMS));
  endfunction

endpackage

// File: rtl/fuyang_dwell_timer.sv
// Loadable down-counter that times the per-beam dwell. Loaded with
// (dwell - 1) on entry to DWELL; o_expire marks the final dwell cycle.
module fuyang_dwell_timer
  import fuyang_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_en,
  input  logic [DWELL_W-1:0] i_cnt,
  output logic               o_expire
);

  dwell_t r_cnt;

  // Load on request, otherwise count down while enabled and stop at zero.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_cnt;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/fuyang_beam_scheduler.sv
// Elevation beam scheduler: steps beam_idx from beam_first to beam_last,
// requests coefficients for each beam, waits for the selector to confirm,
// then holds the beam for the latched dwell length.
module fuyang_beam_scheduler
  import fuyang_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_continuous,
  input  logic [IDX_W-1:0]   i_beam_first,
  input  logic [IDX_W-1:0]   i_beam_last,
  input  logic [DWELL_W-1:0] i_dwell_len,
  input  logic               i_coef_valid,
  output logic [IDX_W-1:0]   o_beam_idx,
  output logic               o_coef_req,
  output logic               o_beam_active,
  output logic               o_beam_done,
  output logic               o_frame_done,
  output logic               o_busy,
  output logic               o_fault
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);

  state_t           r_state;
  beam_idx_t        r_beam_idx;
  beam_idx_t        r_beam_first;
  beam_idx_t        r_beam_last;
  dwell_t           r_dwell_len;
  logic             r_continuous;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_fault;

  state_t           w_state_nxt;
  beam_idx_t        w_idx_nxt;
  logic [TMO_W-1:0] w_tmo_nxt;
  logic             w_fault_nxt;
  logic             w_cfg_load;
  logic             w_dwell_load;
  logic             w_dwell_en;
  logic             w_dwell_expire;
  dwell_t           w_dwell_m1;

  // A zero dwell is treated as a one-cycle dwell.
  assign w_dwell_m1 = (r_dwell_len == '0) ? '0 : (r_dwell_len - 1'b1);

  fuyang_dwell_timer u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_dwell_load),
    .i_en     (w_dwell_en),
    .i_cnt    (w_dwell_m1),
    .o_expire (w_dwell_expire)
  );

  // State, beam index, timeout counter, fault pulse and latched scan config.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_beam_idx   <= '0;
      r_beam_first <= '0;
      r_beam_last  <= '0;
      r_dwell_len  <= '0;
      r_continuous <= 1'b0;
      r_tmo_cnt    <= '0;
      r_fault      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_beam_idx <= w_idx_nxt;
      r_tmo_cnt  <= w_tmo_nxt;
      r_fault    <= w_fault_nxt;
      if (w_cfg_load) begin
        r_beam_first <= i_beam_first;
        r_beam_last  <= i_beam_last;
        r_dwell_len  <= i_dwell_len;
        r_continuous <= i_continuous;
      end
    end
  end

  // Next-state, next beam index and per-state output decode; stop overrides all.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_beam_idx;
    w_tmo_nxt     = r_tmo_cnt;
    w_fault_nxt   = 1'b0;
    w_cfg_load    = 1'b0;
    w_dwell_load  = 1'b0;
    w_dwell_en    = 1'b0;
    o_coef_req    = 1'b0;
    o_beam_active = 1'b0;
    o_beam_done   = 1'b0;
    o_frame_done  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // stop wins over a simultaneous start
        if (i_start && !i_stop) begin
          if (cfg_legal(i_beam_first, i_beam_last)) begin
            w_cfg_load  = 1'b1;
            w_idx_nxt   = i_beam_first;
            w_state_nxt = ST_SELECT;
          end else begin
            w_fault_nxt = 1'b1;
          end
        end
      end
      ST_SELECT: begin
        o_coef_req  = 1'b1;
        w_tmo_nxt   = '0;
        w_state_nxt = ST_WAIT_COEF;
      end
      ST_WAIT_COEF: begin
        if (i_coef_valid) begin
          w_dwell_load = 1'b1;
          w_state_nxt  = ST_DWELL;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_fault_nxt = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmo_nxt = r_tmo_cnt + 1'b1;
        end
      end
      ST_DWELL: begin
        o_beam_active = 1'b1;
        if (w_dwell_expire) begin
          w_state_nxt = ST_NEXT;
        end else begin
          w_dwell_en = 1'b1;
        end
      end
      ST_NEXT: begin
        o_beam_done = 1'b1;
        if (r_beam_idx < r_beam_last) begin
          w_idx_nxt   = r_beam_idx + 1'b1;
          w_state_nxt = ST_SELECT;
        end else begin
          o_frame_done = 1'b1;
          if (r_continuous) begin
            w_idx_nxt   = r_beam_first;
            w_state_nxt = ST_SELECT;
          end else begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_idx_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Abort: back to IDLE with no beam and no pulses this cycle.
    if (i_stop && (r_state != ST_IDLE)) begin
      w_state_nxt  = ST_IDLE;
      w_idx_nxt    = '0;
      w_fault_nxt  = 1'b0;
      w_dwell_load = 1'b0;
      w_dwell_en   = 1'b0;
      o_coef_req   = 1'b0;
      o_beam_done  = 1'b0;
      o_frame_done = 1'b0;
    end
  end

  assign o_beam_idx = r_beam_idx;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_fault    = r_fault;

endmodule

// File: tb/tb_fuyang_beam_scheduler.sv
// Scoreboard bench for fuyang_beam_scheduler. Directed scans push their
// expected pulse events (kind, beam, frame flag, dwell length, cycle) into a
// queue; a monitor pops and compares whenever the DUT pulses coef_req,
// beam_done, frame_done or fault.
module tb_fuyang_beam_scheduler;

  localparam int TMO = 255;

  typedef enum int { EV_REQ = 0, EV_DONE = 1, EV_FAULT = 2, EV_STRAY_FRAME = 3 } ev_kind_t;

  typedef struct {
    ev_kind_t kind;
    int       idx;
    int       frame;
    int       act;
    int       cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_continuous = 1'b0;
  logic [6:0]  i_beam_first = '0;
  logic [6:0]  i_beam_last = '0;
  logic [15:0] i_dwell_len = '0;
  logic        i_coef_valid = 1'b0;
  logic [6:0]  o_beam_idx;
  logic        o_coef_req;
  logic        o_beam_active;
  logic        o_beam_done;
  logic        o_frame_done;
  logic        o_busy;
  logic        o_fault;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  act_run = 0;
  bit  cv_en = 1'b1;
  ev_t exp_q[$];

  fuyang_beam_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_continuous (i_continuous),
    .i_beam_first (i_beam_first),
    .i_beam_last  (i_beam_last),
    .i_dwell_len  (i_dwell_len),
    .i_coef_valid (i_coef_valid),
    .o_beam_idx   (o_beam_idx),
    .o_coef_req   (o_coef_req),
    .o_beam_active(o_beam_active),
    .o_beam_done  (o_beam_done),
    .o_frame_done (o_frame_done),
    .o_busy       (o_busy),
    .o_fault      (o_fault)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Coefficient selector stand-in: valid for one cycle, the cycle after coef_req.
  initial begin
    bit req_now;
    forever begin
      @(negedge clk);
      req_now = o_coef_req;
      @(posedge clk);
      #1;
      i_coef_valid = req_now && cv_en;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int actual, input int expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d, expected %0d (cyc=%0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic push_ev(input ev_kind_t kind, input int idx, input int frame,
                         input int act, input int at);
    ev_t e;
    e.kind = kind; e.idx = idx; e.frame = frame; e.act = act; e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Expected events for nframes complete frames of a scan whose start is
  // driven in cycle t0, with coef_valid one cycle after coef_req.
  task automatic push_scan(input int t0, input int first, input int last,
                           input int dwell, input int nframes);
    int d = (dwell == 0) ? 1 : dwell;
    int p = d + 3;
    int n = last - first + 1;
    for (int f = 0; f < nframes; f++) begin
      for (int b = 0; b < n; b++) begin
        int base = t0 + 1 + (f * n + b) * p;
        push_ev(EV_REQ, first + b, 0, 0, base);
        push_ev(EV_DONE, first + b, (b == n - 1) ? 1 : 0, d, base + 2 + d);
      end
    end
  endtask

  task automatic take(input ev_kind_t kind, input int idx, input int frame, input int act);
    ev_t a;
    ev_t e;
    a.kind = kind; a.idx = idx; a.frame = frame; a.act = act; a.cyc = cyc;
    total = total + 1;
    if (exp_q.size() == 0) begin
      bad = bad + 1;
      $display("FAIL unexpected_event: got kind=%0d idx=%0d frame=%0d act=%0d cyc=%0d, expected none",
               a.kind, a.idx, a.frame, a.act, a.cyc);
    end else begin
      e = exp_q.pop_front();
      if (a != e) begin
        bad = bad + 1;
        $display("FAIL event: got kind=%0d idx=%0d frame=%0d act=%0d cyc=%0d, expected kind=%0d idx=%0d frame=%0d act=%0d cyc=%0d",
                 a.kind, a.idx, a.frame, a.act, a.cyc, e.kind, e.idx, e.frame, e.act, e.cyc);
      end
    end
  endtask

  // Monitor: turn DUT pulses into events and compare with the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (o_coef_req) act_run = 0;
      if (o_beam_active) act_run = act_run + 1;
      if (o_coef_req) take(EV_REQ, int'(o_beam_idx), 0, 0);
      if (o_beam_done) take(EV_DONE, int'(o_beam_idx), int'(o_frame_done), act_run);
      if (o_frame_done && !o_beam_done) take(EV_STRAY_FRAME, int'(o_beam_idx), 1, 0);
      if (o_fault) take(EV_FAULT, int'(o_beam_idx), 0, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic start_scan(input int first, input int last, input int dwell, input bit cont);
    i_beam_first = 7'(first);
    i_beam_last  = 7'(last);
    i_dwell_len  = 16'(dwell);
    i_continuous = cont;
    i_start      = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_beam_idx"}, int'(o_beam_idx), 0);
    check({tag, "_outputs"},
          int'({o_coef_req, o_beam_active, o_beam_done, o_frame_done, o_busy, o_fault}), 0);
  endtask

  initial begin
    int t0;

    // Reset state.
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check_all_zero("after_reset");

    // 1: single frame 3..5, dwell 4, period 7.
    t0 = cyc;
    push_scan(t0, 3, 5, 4, 1);
    start_scan(3, 5, 4, 1'b0);
    wait_until(t0 + 4);
    check("t1_active_in_dwell", int'(o_beam_active), 1);
    check("t1_idx_in_dwell", int'(o_beam_idx), 3);
    wait_until(t0 + 21);
    check("t1_busy_at_last_next", int'(o_busy), 1);
    step();
    check("t1_busy_after_frame", int'(o_busy), 0);
    check("t1_idx_after_frame", int'(o_beam_idx), 0);

    // 2: continuous 70..70, dwell 0 -> frame every 4 cycles; stop in SELECT.
    t0 = cyc;
    push_scan(t0, 70, 70, 0, 3);
    start_scan(70, 70, 0, 1'b1);
    wait_until(t0 + 13);
    check("t2_idx_held", int'(o_beam_idx), 70);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    check("t2_busy_after_stop", int'(o_busy), 0);
    check("t2_idx_after_stop", int'(o_beam_idx), 0);
    step();

    // 3: illegal configurations -> fault pulse, stay idle.
    for (int k = 0; k < 3; k++) begin
      int f = (k == 0) ? 6 : ((k == 1) ? 0 : 3);
      int l = (k == 0) ? 2 : ((k == 1) ? 5 : 71);
      t0 = cyc;
      push_ev(EV_FAULT, 0, 0, 0, t0 + 1);
      start_scan(f, l, 2, 1'b0);
      check("t3_busy_on_bad_cfg", int'(o_busy), 0);
      step();
      check("t3_busy_after_fault", int'(o_busy), 0);
    end

    // 4: coef_valid never arrives -> fault TMO cycles into WAIT_COEF.
    cv_en = 1'b0;
    t0 = cyc;
    push_ev(EV_REQ, 10, 0, 0, t0 + 1);
    push_ev(EV_FAULT, 0, 0, 0, t0 + 2 + TMO);
    start_scan(10, 12, 3, 1'b0);
    wait_until(t0 + 1 + TMO);
    check("t4_busy_before_tmo", int'(o_busy), 1);
    check("t4_idx_before_tmo", int'(o_beam_idx), 10);
    step();
    check("t4_busy_after_tmo", int'(o_busy), 0);
    check("t4_idx_after_tmo", int'(o_beam_idx), 0);
    cv_en = 1'b1;
    step();

    // 5a: start and stop together in IDLE -> ignored.
    i_stop = 1'b1;
    start_scan(4, 6, 2, 1'b0);
    i_stop = 1'b0;
    check("t5_busy_start_stop", int'(o_busy), 0);
    step();
    check("t5_busy_start_stop_2", int'(o_busy), 0);

    // 5b: start while busy and config changes mid-scan have no effect.
    t0 = cyc;
    push_scan(t0, 2, 3, 2, 1);
    start_scan(2, 3, 2, 1'b0);
    wait_until(t0 + 3);
    i_dwell_len  = 16'd7;
    i_beam_first = 7'd10;
    i_beam_last  = 7'd20;
    i_continuous = 1'b1;
    i_start      = 1'b1;
    step();
    i_start = 1'b0;
    wait_until(t0 + 12);
    check("t5_busy_after_frame", int'(o_busy), 0);

    // 6: reset during the dwell of beam 4 -> all outputs zero, no done pulses.
    t0 = cyc;
    push_ev(EV_REQ, 3, 0, 0, t0 + 1);
    push_ev(EV_DONE, 3, 0, 4, t0 + 7);
    push_ev(EV_REQ, 4, 0, 0, t0 + 8);
    start_scan(3, 5, 4, 1'b0);
    wait_until(t0 + 11);
    check("t6_active_before_rst", int'(o_beam_active), 1);
    rst = 1'b1;
    step();
    check_all_zero("t6_rst");
    rst = 1'b0;
    repeat (6) step();
    check_all_zero("t6_after_rst");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
